mem_access_ctrl: RTL and testbench

- Initiator side of the word-addressed data memory interface: the MEM-stage load/store controller that drives mem_read/mem_write/addr/write_data and consumes the combinational read_data.
- Converts RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. Sub-word stores use a two-cycle read-modify-write, because the memory only writes whole words.
- Detects misaligned, illegal-funct3 and out-of-range accesses.
- Provides a valid/ready handshake to the pipeline, which stalls while req_ready=0.

---
 rtl/mem_access_ctrl_pkg.sv | 44 ++++
 rtl/mem_access_ctrl_lsu_align.sv | 62 ++++++
 rtl/mem_access_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store controller.
//   - funct3 encodings for RV32I loads/stores
//   - controller state enum
//   - request legality helpers (funct3 legality, alignment)
package mem_access_ctrl_pkg;

   localparam int unsigned F3_W_BITS = 3;

   localparam logic [F3_W_BITS-1:0] F3_B  = 3'b000;
   localparam logic [F3_W_BITS-1:0] F3_H  = 3'b001;
   localparam logic [F3_W_BITS-1:0] F3_W  = 3'b010;
   localparam logic [F3_W_BITS-1:0] F3_BU = 3'b100;
   localparam logic [F3_W_BITS-1:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCESS = 3'd1,
      RMW_RD = 3'd2,
      RMW_WR = 3'd3,
      RESP   = 3'd4
   } state_t;

   // Unsigned variants exist only for loads.
   function automatic logic f3_illegal(input logic store, input logic [F3_W_BITS-1:0] f3);
      logic bad;
      case (f3)
         F3_B, F3_H, F3_W: bad = 1'b0;
         F3_BU, F3_HU:     bad = store;
         default:          bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic misaligned(input logic [F3_W_BITS-1:0] f3, input logic [1:0] lane);
      logic bad;
      case (f3)
         F3_W:         bad = (lane != 2'b00);
         F3_H, F3_HU:  bad = lane[0];
         default:      bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_lsu_align.sv
// Combinational byte-lane alignment for the load/store controller.
//   funct3  : access size / signedness
//   lane    : byte offset addr[1:0]
//   rdata   : word read from memory
//   wdata   : low half of store data (SB uses [7:0], SH uses [15:0])
//   load_c  : extracted and sign/zero-extended load value
//   merge_c : rdata with the addressed byte/half replaced by wdata
module mem_access_ctrl_lsu_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] rdata,
   input  logic [15:0] wdata,
   output logic [31:0] load_c,
   output logic [31:0] merge_c
);

   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [31:0] shifted;
   logic [31:0] mask;
   logic [31:0] ins;

   assign byte_sh = {lane, 3'b000};
   assign half_sh = {lane[1], 4'b0000};

   // Load extract: bring the addressed lane down to bit 0.
   always_comb begin
      shifted = rdata >> byte_sh;
      case (funct3)
         F3_B:    load_c = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   load_c = {24'h000000, shifted[7:0]};
         F3_H:    load_c = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   load_c = {16'h0000, shifted[15:0]};
         F3_W:    load_c = rdata;
         default: load_c = 32'h0;
      endcase
   end

   // Store merge: little-endian lane replacement into the read word.
   always_comb begin
      mask = 32'h0;
      ins  = 32'h0;
      case (funct3)
         F3_B: begin
            mask = 32'h0000_00FF << byte_sh;
            ins  = 32'(wdata[7:0]) << byte_sh;
         end
         F3_H: begin
            mask = 32'h0000_FFFF << half_sh;
            ins  = 32'(wdata) << half_sh;
         end
         default: begin
            mask = 32'h0;
            ins  = 32'h0;
         end
      endcase
      merge_c = (rdata & ~mask) | (ins & mask);
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller (initiator side of a word-addressed memory).
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : pipeline handshake, ready only in IDLE
//   req_store/funct3/addr/wdata : request fields, latched on acceptance
//   resp_valid/resp_err      : one-cycle completion pulse and error flag
//   load_data                : formatted load result, held until next response
//   mem_read/mem_write/mem_addr/mem_wdata : registered memory controls
//   mem_rdata                : combinational read data from memory
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] load_data,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned WORD_W = 32;

   state_t              state_q, state_d;
   logic                store_q, store_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [1:0]          lane_q, lane_d;
   logic [15:0]         wlow_q, wlow_d;

   logic                ready_d, resp_valid_d, resp_err_d, mem_read_d, mem_write_d;
   logic [WORD_W-1:0]   load_data_d, mem_addr_d, mem_wdata_d;

   logic                req_err_c;
   logic [WORD_W-1:0]   load_c, merge_c;

   // Legality of the request currently on the input bus.
   assign req_err_c = f3_illegal(req_store, req_funct3)
                    | misaligned(req_funct3, req_addr[1:0])
                    | ({2'b00, req_addr[31:2]} >= WORD_W'(MEM_WORDS));

   mem_access_ctrl_lsu_align u_align (
      .funct3  (funct3_q),
      .lane    (lane_q),
      .rdata   (mem_rdata),
      .wdata   (wlow_q),
      .load_c  (load_c),
      .merge_c (merge_c)
   );

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         store_q    <= 1'b0;
         funct3_q   <= F3_B;
         lane_q     <= 2'b00;
         wlow_q     <= 16'h0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         load_data  <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state_q    <= state_d;
         store_q    <= store_d;
         funct3_q   <= funct3_d;
         lane_q     <= lane_d;
         wlow_q     <= wlow_d;
         req_ready  <= ready_d;
         resp_valid <= resp_valid_d;
         resp_err   <= resp_err_d;
         load_data  <= load_data_d;
         mem_read   <= mem_read_d;
         mem_write  <= mem_write_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
      end
   end

   // Next state and next registered outputs; each output reflects the state being entered.
   always_comb begin
      state_d      = state_q;
      store_d      = store_q;
      funct3_d     = funct3_q;
      lane_d       = lane_q;
      wlow_d       = wlow_q;
      ready_d      = 1'b0;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      load_data_d  = load_data;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               store_d    = req_store;
               funct3_d   = req_funct3;
               lane_d     = req_addr[1:0];
               wlow_d     = req_wdata[15:0];
               mem_addr_d = {req_addr[31:2], 2'b00};
               if (req_err_c) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  load_data_d  = '0;
               end else if (!req_store) begin
                  state_d    = ACCESS;
                  mem_read_d = 1'b1;
               end else if (req_funct3 == F3_W) begin
                  state_d     = ACCESS;
                  mem_write_d = 1'b1;
                  mem_wdata_d = req_wdata;
               end else begin
                  state_d    = RMW_RD;
                  mem_read_d = 1'b1;
               end
            end else begin
               ready_d = 1'b1;
            end
         end
         ACCESS: begin
            if (!store_q) begin
               load_data_d = load_c;
            end
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         RMW_RD: begin
            mem_wdata_d = merge_c;
            mem_write_d = 1'b1;
            state_d     = RMW_WR;
         end
         RMW_WR: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         RESP: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed steps followed by random
// requests, checked against a byte-array reference model of memory.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] load_data;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   // Memory the DUT talks to.
   logic [31:0] mem [0:255] = '{default: 32'h0};
   // Independent reference: byte-addressed image of the same memory.
   logic [7:0]  ref_b [0:1023];

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
   end

   mem_access_ctrl #(.MEM_WORDS(256)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .load_data  (load_data),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [31:0] base;
      base = a & 32'h3FC;
      return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
   endfunction

   // One request through the handshake, checked for timing, memory traffic and result.
   task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] ld);
      int          size;
      int          lat;
      int          resp_k;
      int          waited;
      logic        legal, err;
      logic [7:0]  rdm, wrm, exp_rdm, exp_wrm;
      logic [31:0] wr_word, exp_ld, v;
      bit          both;

      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      legal = (size != 0) && !(st && f3[2]);
      err   = !legal || ((a % size) != 0) || ((a / 4) >= 256);

      exp_ld = 32'h0;
      if (!err && !st) begin
         v = 32'h0;
         for (int i = 0; i < size; i++) v = v | (32'(ref_b[a+i]) << (8*i));
         if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
         if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
         exp_ld = v;
      end

      if (err)                         begin lat = 1; exp_rdm = 8'h00; exp_wrm = 8'h00; end
      else if (!st)                    begin lat = 2; exp_rdm = 8'h02; exp_wrm = 8'h00; end
      else if (size == 4)              begin lat = 2; exp_rdm = 8'h00; exp_wrm = 8'h02; end
      else                             begin lat = 3; exp_rdm = 8'h02; exp_wrm = 8'h04; end

      waited = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      chk("ready_before_req", 32'(req_ready), 32'h1);

      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;

      rdm = 8'h0; wrm = 8'h0; wr_word = 32'h0; resp_k = 0; both = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         rdm[k] = mem_read;
         wrm[k] = mem_write;
         if (mem_read && mem_write) both = 1;
         if (mem_read || mem_write) chk("mem_addr", mem_addr, {a[31:2], 2'b00});
         if (mem_write) wr_word = mem_wdata;
         if (resp_valid) begin
            resp_k = k;
            req_valid = 1'b0;
            break;
         end
         // Garbage on the request bus while busy must be ignored.
         req_store  = 1'($urandom);
         req_funct3 = 3'($urandom);
         req_addr   = $urandom;
         req_wdata  = $urandom;
      end
      req_valid = 1'b0;

      chk("resp_latency", 32'(resp_k), 32'(lat));
      chk("rd_write_overlap", 32'(both), 32'h0);
      chk("mem_read_cycles", 32'(rdm), 32'(exp_rdm));
      chk("mem_write_cycles", 32'(wrm), 32'(exp_wrm));
      chk("resp_err", 32'(resp_err), 32'(err));
      if (err || !st) chk("load_data", load_data, exp_ld);

      if (!err && st) begin
         for (int i = 0; i < size; i++) ref_b[a+i] = 8'(wd >> (8*i));
         chk("store_word", wr_word, ref_word(a));
      end
      ld = load_data;

      @(negedge clk);
      chk("resp_pulse", 32'(resp_valid), 32'h0);
      chk("ready_after_resp", 32'(req_ready), 32'h1);
   endtask

   initial begin
      logic [31:0] ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;

      for (int i = 0; i < 1024; i++) ref_b[i] = 8'h00;
      rst = 1'b1; req_valid = 1'b0; req_store = 1'b0;
      req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;

      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'h1);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_resp_err", 32'(resp_err), 32'h0);
      chk("rst_load_data", load_data, 32'h0);
      chk("rst_mem_read", 32'(mem_read), 32'h0);
      chk("rst_mem_write", 32'(mem_write), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      rst = 1'b0;

      // Word store/load.
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, ld);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, ld);
      chk("lw_10", ld, 32'hDEADBEEF);

      // Byte read-modify-write and byte loads.
      do_req(1'b1, 3'b000, 32'h11, 32'h000000AA, ld);
      chk("sb_word", mem[4], 32'hDEADAAEF);
      do_req(1'b0, 3'b000, 32'h11, 32'h0, ld);
      chk("lb_11", ld, 32'hFFFFFFAA);
      do_req(1'b0, 3'b100, 32'h11, 32'h0, ld);
      chk("lbu_11", ld, 32'h000000AA);

      // Half read-modify-write and half loads.
      do_req(1'b1, 3'b001, 32'h12, 32'h00008001, ld);
      chk("sh_word", mem[4], 32'h8001AAEF);
      do_req(1'b0, 3'b001, 32'h12, 32'h0, ld);
      chk("lh_12", ld, 32'hFFFF8001);
      do_req(1'b0, 3'b101, 32'h12, 32'h0, ld);
      chk("lhu_12", ld, 32'h00008001);

      // Error cases and range boundary.
      do_req(1'b0, 3'b010, 32'h13, 32'h0, ld);
      do_req(1'b1, 3'b001, 32'h11, 32'h1234, ld);
      do_req(1'b0, 3'b011, 32'h10, 32'h0, ld);
      do_req(1'b1, 3'b100, 32'h10, 32'h0, ld);
      do_req(1'b0, 3'b010, 32'h400, 32'h0, ld);
      do_req(1'b0, 3'b010, 32'h3FC, 32'h0, ld);

      // Reset during the read phase of SB abandons it.
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h10; req_wdata = 32'h00000055;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_rmw_rd", 32'(mem_read), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", 32'(req_ready), 32'h1);
      chk("abort_no_write", 32'(mem_write), 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_no_write", 32'(mem_write), 32'h0);
         chk("abort_no_resp", 32'(resp_valid), 32'h0);
      end
      do_req(1'b0, 3'b010, 32'h10, 32'h0, ld);
      chk("abort_word_kept", ld, 32'h8001AAEF);

      // Random traffic against the reference model.
      for (int n = 0; n < 60; n++) begin
         st = 1'($urandom);
         f3 = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 9) == 0) ? (32'h400 + 32'($urandom_range(0, 255)))
                                          : 32'($urandom_range(0, 63));
         do_req(st, f3, a, $urandom, ld);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
